display_mux_driver: RTL and testbench
=====================================

Name: display_mux_driver

Overview:
Parametrised multi-digit, time-multiplexed 7-segment driver for the display path. It latches an N-digit packed nibble value, decodes each nibble in BCD or hex mode, and scans the digits round-robin at a programmable rate. It also provides tear-free value updates at frame boundaries and optional leading-zero blanking. It sits between the code-conversion logic and the board's anode and segment pins.

Parameters:
N_DIGITS, 4, number of multiplexed digits (legal range 1..8)
REFRESH_DIV, 50000, clk cycles each digit stays lit (legal minimum 2)
ANODE_ACTIVE_LOW, 1, 1: a lit digit drives its anode bit 0; 0: it drives 1
SEG_ACTIVE_LOW, 0, 1: all segment bits are inverted at the output

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
load  in  1  capture value_in this cycle
value_in  in  4*N_DIGITS  packed nibbles; nibble k = digit k; digit 0 is least significant/rightmost
hex_mode  in  1  1: nibbles 10-15 show A,b,C,d,E,F; 0: nibbles 10-15 are blank
blank_lz  in  1  1: enable leading-zero blanking
anodes  out  N_DIGITS  one-hot digit enable (polarity per ANODE_ACTIVE_LOW)
segments  out  7  bit6=a, bit5=b, ..., bit0=g; 1 = lit before SEG_ACTIVE_LOW inversion
frame_start  out  1  one-cycle pulse when scanning returns to digit 0
update_ack  out  1  one-cycle pulse when a pending value is committed

Behaviour:
- Configuration is fixed at reset. "Live" means at the last cycle of a scan frame.
- Reset (synchronous, rst=1 at clk edge):
  - slot counter=0, digit index idx=0, committed=0, pending_valid=0.
  - anodes = all inactive; segments = all unlit; frame_start=0; update_ack=0.
  - Reset mid-scan discards any pending value.
- Slot counter:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - Width is $clog2(REFRESH_DIV).
  - On wrap, idx advances; idx wraps from N_DIGITS-1 to 0.
  - With N_DIGITS=1, idx stays 0 and every wrap is a frame boundary.
- Frame boundary: the cycle where the counter wraps and idx==N_DIGITS-1. At the next edge:
  - committed <= (load ? value_in : pending, if pending_valid).
  - frame_start <= 1.
  - update_ack <= 1 only if a value was committed.
- Load handshake:
  - load=1 outside a boundary cycle: pending <= value_in, pending_valid <= 1.
  - load in consecutive cycles: the last one wins.
  - load on the boundary cycle: value_in goes directly to committed.
  - After a commit, pending_valid clears (unless load was also high on that cycle). load is never refused.
- Outputs:
  - Registered from the current idx and committed value, so they lag idx by exactly 1 cycle.
  - First lit output: the cycle after rst is released shows digit 0.
  - Each digit is lit for exactly REFRESH_DIV cycles.
- Glyphs (a..g, hex):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=73
  - A=77, b=1F, C=4E, d=3D, E=4F, F=47
  - BCD mode nibbles 10-15 = 00 (blank).
- Leading-zero blanking:
  - Applies when blank_lz=1 at display time.
  - Digit k>0 shows 00 if its nibble and all higher nibbles are 0.
  - Digit 0 is never blanked; 0x0000 shows "0".
- The anode stays active for blanked digits; only the segments go dark.
- hex_mode and blank_lz are sampled every cycle, with no boundary synchronisation.

Test Plan:
- Reset release, N_DIGITS=4, REFRESH_DIV=4, no load:
  - anodes=1110 for cycles 1-4, 1101 for 5-8, 1011 for 9-12, 0111 for 13-16, then repeats.
  - segments=7E on digit 0 and 00 on digits 1-3 when blank_lz=1.
  - frame_start pulses at cycle 16.
- load value_in=16'h1234 at cycle 5:
  - Display remains 0 until the boundary.
  - update_ack pulses with frame_start.
  - Next frame: digit0=33, digit1=79, digit2=6D, digit3=30.
- load 16'h00AF with hex_mode=1, blank_lz=1:
  - Digits 0/1 = 47/77; digits 2/3 = 00 with anodes still cycling.
  - Same value with hex_mode=0: digits 0/1 = 00.
- Loads of 16'h1111 then 16'h2222 in consecutive cycles mid-frame:
  - Only 2222 is committed; a single update_ack pulse.
- Load on the exact boundary cycle: committed the same boundary; update_ack the next cycle.
- rst asserted mid-frame with a pending load: outputs go inactive next cycle and the pending value is discarded.

Source files
------------

// File: rtl/display_mux_driver_if.sv
// Bus bundle for display_mux_driver: the value-load handshake, the display mode
// controls, and the scanned anode/segment outputs.
interface display_mux_driver_if #(
  parameter int N_DIGITS = 4
) ();
  logic                    load;
  logic [4*N_DIGITS-1:0]   value_in;
  logic                    hex_mode;
  logic                    blank_lz;
  logic [N_DIGITS-1:0]     anodes;
  logic [6:0]              segments;
  logic                    frame_start;
  logic                    update_ack;

  modport master (
    output load, value_in, hex_mode, blank_lz,
    input  anodes, segments, frame_start, update_ack
  );

  modport slave (
    input  load, value_in, hex_mode, blank_lz,
    output anodes, segments, frame_start, update_ack
  );
endinterface

// File: rtl/display_mux_driver.sv
// Time-multiplexed N-digit 7-segment driver with BCD/hex decode, leading-zero
// blanking and tear-free value commits at scan-frame boundaries.
module display_mux_driver #(
  parameter int N_DIGITS         = 4,
  parameter int REFRESH_DIV      = 50000,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 0
) (
  input logic                  clk,
  input logic                  rst,
  display_mux_driver_if.slave  bus
);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] ANODE_OFF = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]          SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [4*N_DIGITS-1:0] r_committed;
  logic [4*N_DIGITS-1:0] r_pending;
  logic                  r_pending_valid;
  logic [N_DIGITS-1:0]   r_anodes;
  logic [6:0]            r_segments;
  logic                  r_frame_start;
  logic                  r_update_ack;

  logic                  w_wrap;
  logic                  w_boundary;
  logic [3:0]            w_nibble;
  logic [N_DIGITS-1:0]   w_onehot;
  logic [4*N_DIGITS-1:0] w_upper;
  logic                  w_lz_blank;
  logic [6:0]            w_glyph;
  logic [6:0]            w_seg_lit;

  assign w_wrap     = (r_cnt == CNT_LAST);
  assign w_boundary = w_wrap && (r_idx == IDX_LAST);

  always_comb begin
    w_nibble = '0;
    w_onehot = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (IDX_W'(k) == r_idx) begin
        w_nibble    = r_committed[4*k +: 4];
        w_onehot[k] = 1'b1;
      end
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  assign w_upper    = r_committed >> {r_idx, 2'b00};
  assign w_lz_blank = bus.blank_lz && (r_idx != '0) && (w_upper == '0);

  always_comb begin
    w_glyph = 7'h00;
    case (w_nibble)
      4'h0: w_glyph = 7'h7E;
      4'h1: w_glyph = 7'h30;
      4'h2: w_glyph = 7'h6D;
      4'h3: w_glyph = 7'h79;
      4'h4: w_glyph = 7'h33;
      4'h5: w_glyph = 7'h5B;
      4'h6: w_glyph = 7'h5F;
      4'h7: w_glyph = 7'h70;
      4'h8: w_glyph = 7'h7F;
      4'h9: w_glyph = 7'h73;
      4'hA: w_glyph = bus.hex_mode ? 7'h77 : 7'h00;
      4'hB: w_glyph = bus.hex_mode ? 7'h1F : 7'h00;
      4'hC: w_glyph = bus.hex_mode ? 7'h4E : 7'h00;
      4'hD: w_glyph = bus.hex_mode ? 7'h3D : 7'h00;
      4'hE: w_glyph = bus.hex_mode ? 7'h4F : 7'h00;
      4'hF: w_glyph = bus.hex_mode ? 7'h47 : 7'h00;
      default: w_glyph = 7'h00;
    endcase
  end

  assign w_seg_lit = w_lz_blank ? 7'h00 : w_glyph;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt           <= '0;
      r_idx           <= '0;
      r_committed     <= '0;
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
      r_anodes        <= ANODE_OFF;
      r_segments      <= SEG_OFF;
      r_frame_start   <= 1'b0;
      r_update_ack    <= 1'b0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
      r_frame_start <= w_boundary;
      r_update_ack  <= w_boundary && (bus.load || r_pending_valid);
      // A load on the boundary cycle bypasses the pending slot entirely.
      if (w_boundary) begin
        if (bus.load) begin
          r_committed <= bus.value_in;
        end else if (r_pending_valid) begin
          r_committed <= r_pending;
        end
        r_pending_valid <= 1'b0;
      end else if (bus.load) begin
        r_pending       <= bus.value_in;
        r_pending_valid <= 1'b1;
      end
      r_anodes   <= (ANODE_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
      r_segments <= (SEG_ACTIVE_LOW != 0) ? ~w_seg_lit : w_seg_lit;
    end
  end

  assign bus.anodes      = r_anodes;
  assign bus.segments    = r_segments;
  assign bus.frame_start = r_frame_start;
  assign bus.update_ack  = r_update_ack;
endmodule

// File: tb/tb_display_mux_driver.sv
// Bench for display_mux_driver: time-indexed reference model checked every cycle,
// a table of decoded-frame vectors, and directed load/reset corner sequences.
module tb_display_mux_driver;
  localparam int N  = 4;
  localparam int RD = 4;
  localparam int FRAME = N * RD;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  display_mux_driver_if #(.N_DIGITS(N)) bus ();

  display_mux_driver #(
    .N_DIGITS(N), .REFRESH_DIV(RD), .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] glyph_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // reference state: edges since reset, committed and pending values
  int          mdl_n = 0;
  logic [15:0] mdl_committed = '0;
  logic [15:0] mdl_pending = '0;
  logic        mdl_pv = 1'b0;

  function automatic logic [6:0] ref_seg(input logic [15:0] c, input int d,
                                         input logic h, input logic b);
    int upper;
    int nib;
    upper = int'(c) >> (4 * d);
    nib   = upper % 16;
    if (b && d > 0 && upper == 0) return 7'h00;
    if (!h && nib > 9) return 7'h00;
    return glyph_tab[nib];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic r, input logic l, input logic [15:0] v,
                      input logic h, input logic b);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_fs;
    logic       e_ack;
    int         nn;
    int         d;
    @(negedge clk);
    rst          = r;
    bus.load     = l;
    bus.value_in = v;
    bus.hex_mode = h;
    bus.blank_lz = b;
    nn = mdl_n + 1;
    if (r) begin
      e_an = 4'hF; e_seg = 7'h00; e_fs = 1'b0; e_ack = 1'b0;
    end else begin
      d     = ((nn - 1) / RD) % N;
      e_an  = ~(4'b0001 << d);
      e_seg = ref_seg(mdl_committed, d, h, b);
      e_fs  = (nn % FRAME) == 0;
      e_ack = e_fs && (l || mdl_pv);
    end
    @(posedge clk);
    #1;
    check("anodes", 32'(bus.anodes), 32'(e_an));
    check("segments", 32'(bus.segments), 32'(e_seg));
    check("frame_start", 32'(bus.frame_start), 32'(e_fs));
    check("update_ack", 32'(bus.update_ack), 32'(e_ack));
    if (r) begin
      mdl_n = 0; mdl_committed = '0; mdl_pv = 1'b0;
    end else begin
      mdl_n = nn;
      if (e_fs) begin
        if (l) mdl_committed = v;
        else if (mdl_pv) mdl_committed = mdl_pending;
        mdl_pv = 1'b0;
      end else if (l) begin
        mdl_pending = v; mdl_pv = 1'b1;
      end
    end
  endtask

  typedef struct {
    logic [15:0] value;
    logic        hex;
    logic        blz;
    logic [6:0]  exp_seg [4];
  } vec_t;

  vec_t vecs [9];

  logic       cur_h;
  logic       cur_b;
  logic [7:0] obs [4];
  int         acks;
  bit         seen;

  initial begin
    vecs[0] = '{16'h1234, 1'b0, 1'b1, '{7'h33, 7'h79, 7'h6D, 7'h30}};
    vecs[1] = '{16'h00AF, 1'b1, 1'b1, '{7'h47, 7'h77, 7'h00, 7'h00}};
    vecs[2] = '{16'h00AF, 1'b0, 1'b1, '{7'h00, 7'h00, 7'h00, 7'h00}};
    vecs[3] = '{16'h00AF, 1'b1, 1'b0, '{7'h47, 7'h77, 7'h7E, 7'h7E}};
    vecs[4] = '{16'h0000, 1'b0, 1'b1, '{7'h7E, 7'h00, 7'h00, 7'h00}};
    vecs[5] = '{16'h0000, 1'b1, 1'b0, '{7'h7E, 7'h7E, 7'h7E, 7'h7E}};
    vecs[6] = '{16'h89CD, 1'b1, 1'b1, '{7'h3D, 7'h4E, 7'h73, 7'h7F}};
    vecs[7] = '{16'h0B0E, 1'b1, 1'b1, '{7'h4F, 7'h7E, 7'h1F, 7'h00}};
    vecs[8] = '{16'h5670, 1'b0, 1'b1, '{7'h7E, 7'h70, 7'h5F, 7'h5B}};

    rst = 1'b1;
    bus.load = 1'b0; bus.value_in = '0; bus.hex_mode = 1'b0; bus.blank_lz = 1'b1;

    // reset, then two idle frames: anode walk, digit 0 shows "0", frame_start at 16
    tick(1, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 1);
    for (int i = 0; i < 2 * FRAME + 3; i++) tick(0, 0, 0, 0, 1);

    // table-driven decoded frames
    foreach (vecs[j]) begin
      cur_h = vecs[j].hex;
      cur_b = vecs[j].blz;
      while ((mdl_n % FRAME) != 5) tick(0, 0, 0, cur_h, cur_b);
      tick(0, 1, vecs[j].value, cur_h, cur_b);
      seen = 1'b0;
      for (int i = 0; i < 3 * FRAME && !seen; i++) begin
        tick(0, 0, 0, cur_h, cur_b);
        if (bus.frame_start) seen = 1'b1;
      end
      check("frame_start_seen", 32'(seen), 32'd1);
      for (int k = 0; k < N; k++) obs[k] = 8'hFF;
      for (int i = 0; i < FRAME; i++) begin
        tick(0, 0, 0, cur_h, cur_b);
        for (int k = 0; k < N; k++)
          if (bus.anodes == ~(4'b0001 << k)) obs[k] = {1'b0, bus.segments};
      end
      for (int k = 0; k < N; k++)
        check($sformatf("table%0d_digit%0d", j, k), 32'(obs[k]), {25'd0, vecs[j].exp_seg[k]});
    end

    // back-to-back loads mid-frame: last wins, one ack
    while ((mdl_n % FRAME) != 5) tick(0, 0, 0, 0, 1);
    tick(0, 1, 16'h1111, 0, 1);
    tick(0, 1, 16'h2222, 0, 1);
    acks = 0;
    for (int i = 0; i < FRAME + 2; i++) begin
      tick(0, 0, 0, 0, 1);
      if (bus.update_ack) acks++;
    end
    check("b2b_ack_count", 32'(acks), 32'd1);
    check("b2b_digit1", 32'(ref_seg(16'h2222, 1, 0, 1)), 32'h6D);

    // load exactly on the boundary cycle
    while (((mdl_n + 1) % FRAME) != 0) tick(0, 0, 0, 0, 1);
    tick(0, 1, 16'h4321, 0, 1);
    check("boundary_ack", 32'(bus.update_ack), 32'd1);
    tick(0, 0, 0, 0, 1);
    check("boundary_digit0", 32'(bus.segments), 32'h30);

    // reset mid-frame discards the pending value
    while ((mdl_n % FRAME) != 6) tick(0, 0, 0, 0, 1);
    tick(0, 1, 16'h9999, 0, 1);
    tick(0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 1);
    check("rst_anodes", 32'(bus.anodes), 32'hF);
    check("rst_segments", 32'(bus.segments), 32'h0);
    acks = 0;
    for (int i = 0; i < FRAME + 4; i++) begin
      tick(0, 0, 0, 0, 1);
      if (bus.update_ack) acks++;
    end
    check("rst_discard_ack", 32'(acks), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 499) == 0), ($urandom_range(0, 7) == 0),
           16'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
